// File: rtl/ifmap_loader.sv
// ifmap_loader: packs 8-bit activations little-endian into 32-bit words
// and writes them to sram_ifmap from a programmable base word address.
//
// Ports:
//   CLK, RSTn            clock, async active-low reset
//   start                launch a load (sampled in IDLE only)
//   base_addr, byte_len  load descriptor (sampled with start)
//   in_data, in_valid    activation byte stream
//   in_ready             byte accepted on edges with in_valid & in_ready
//   busy                 load in progress (FILL or WRITE)
//   done                 one-cycle completion pulse
//   ADDR, WE, DI         SRAM write port; ADDR/DI hold outside WRITE
module ifmap_loader #(
  parameter int ADDR_BIT = 5
) (
  input  logic                CLK,
  input  logic                RSTn,
  input  logic                start,
  input  logic [ADDR_BIT-1:0] base_addr,
  input  logic [ADDR_BIT+2:0] byte_len,
  input  logic [7:0]          in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic                busy,
  output logic                done,
  output logic [ADDR_BIT-1:0] ADDR,
  output logic                WE,
  output logic [31:0]         DI
);

  localparam int RW = ADDR_BIT + 3;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    WRITE,
    DONE
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [RW-1:0]       rem_q;
  logic [1:0]          lane_q;
  logic [31:0]         pack_q;
  logic [ADDR_BIT-1:0] waddr_q;
  logic [ADDR_BIT-1:0] addr_q;
  logic [31:0]         di_q;

  logic        accept;
  logic        last;
  logic [31:0] pack_nx;

  assign accept = (state_q == FILL) & in_valid;
  assign last   = (lane_q == 2'd3) | (rem_q == RW'(1));

  always_comb begin
    pack_nx = pack_q;
    pack_nx[8*lane_q +: 8] = in_data;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = (byte_len == '0) ? DONE : FILL;
        end
      end
      FILL: begin
        if (accept && last) begin
          state_d = WRITE;
        end
      end
      WRITE: begin
        state_d = (rem_q != '0) ? FILL : DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // The SRAM address/data registers are loaded on the edge that takes
  // the word's final byte, so they are valid throughout WRITE and then
  // simply hold.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      rem_q   <= '0;
      lane_q  <= '0;
      pack_q  <= '0;
      waddr_q <= '0;
      addr_q  <= '0;
      di_q    <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start && byte_len != '0) begin
            rem_q   <= byte_len;
            waddr_q <= base_addr;
            pack_q  <= '0;
            lane_q  <= '0;
          end
        end
        FILL: begin
          if (accept) begin
            pack_q <= pack_nx;
            lane_q <= lane_q + 2'd1;
            rem_q  <= rem_q - RW'(1);
            if (last) begin
              addr_q <= waddr_q;
              di_q   <= pack_nx;
            end
          end
        end
        WRITE: begin
          waddr_q <= waddr_q + ADDR_BIT'(1);
          pack_q  <= '0;
          lane_q  <= '0;
        end
        default: begin
        end
      endcase
    end
  end

  assign in_ready = (state_q == FILL);
  assign busy     = (state_q == FILL) | (state_q == WRITE);
  assign done     = (state_q == DONE);
  assign WE       = (state_q == WRITE);
  assign ADDR     = addr_q;
  assign DI       = di_q;

endmodule

// File: doc/ifmap_loader.md
# ifmap_loader

Byte-stream packer that fills the ifmap SRAM ahead of the PE array. It accepts 8-bit activations on a valid/ready stream and packs four consecutive bytes little-endian into one 32-bit word. It then issues single-cycle writes into `sram_ifmap`, starting at a programmable word address. It sits directly upstream of `sram_ifmap` and drives that macro's `ADDR`/`WE`/`DI` during load. The top level muxes `ADDR` back to the read sequencer when `busy` is low.

## Interface

- `ADDR_BIT`, default 5: SRAM word-address width; must match `sram_ifmap`.
- `CLK`  in  1: clock; all state updates on the rising edge.
- `RSTn`  in  1: asynchronous, active-low reset.
- `start`  in  1: sampled only in IDLE; launches a load.
- `base_addr`  in  ADDR_BIT: first SRAM word address; sampled with `start`.
- `byte_len`  in  ADDR_BIT+3: number of bytes to load, 0..4·2^ADDR_BIT; sampled with `start`.
- `in_data`  in  8: activation byte.
- `in_valid`  in  1: `in_data` valid.
- `in_ready`  out  1: loader accepts a byte this cycle; the byte transfers on an edge where `in_valid & in_ready`.
- `busy`  out  1: load in progress; the top level selects this block's SRAM port while it is high.
- `done`  out  1: one-cycle pulse on load completion.
- `ADDR`  out  ADDR_BIT: SRAM word address.
- `WE`  out  1: SRAM write enable, one cycle per word.
- `DI`  out  32: SRAM write data.

## Operation

- States: IDLE, FILL, WRITE, DONE.
- Registers:
  - `rem`, ADDR_BIT+3 bits: bytes still to accept.
  - `lane`, 2 bits: next byte position.
  - `pack`, 32 bits: word being assembled.
  - `waddr`, ADDR_BIT bits: next write address.
- IDLE:
  - `start`=1 with `byte_len`≠0: latch `rem`=`byte_len`, `waddr`=`base_addr`, clear `pack` and `lane`, go to FILL.
  - `start`=1 with `byte_len`=0: go directly to DONE; no write occurs.
- FILL:
  - `in_ready`=1.
  - On each accepted byte, write it to `pack[8·lane +: 8]`, then increment `lane` and decrement `rem`.
  - Go to WRITE when the accepted byte fills lane 3 or makes `rem` reach 0.
- WRITE:
  - `in_ready`=0, `WE`=1, `ADDR`=`waddr`, `DI`=`pack`.
  - Then `waddr`+1, with modulo-2^ADDR_BIT wrap.
  - Clear `pack` and `lane`.
  - Next state is FILL if `rem`≠0, otherwise DONE.
- DONE: `done`=1 for exactly one cycle, then return to IDLE.
- Partial final word: lanes not written stay 0, so the word is zero-padded in its upper bytes.
- `start` outside IDLE is ignored; `base_addr` and `byte_len` may change freely after sampling.
- Gaps in `in_valid` simply stall FILL; there is no timeout.
- A `byte_len` above 4·2^ADDR_BIT is illegal. Behaviour is address wrap with overwrite; no error flag.
- `busy`=1 in FILL and WRITE; 0 in IDLE and DONE.

## Timing

- All outputs are registered or decoded from the state register. There is no combinational path from `in_valid` to `in_ready`.
- Reset values: state=IDLE, `in_ready`=0, `busy`=0, `done`=0, `WE`=0, `ADDR`=0, `DI`=0, and all internal registers 0.
- Asserting `RSTn` mid-load aborts immediately:
  - No further `WE`.
  - A partial word is discarded.
  - `done` is not pulsed.
- Latency from `start` edge to first FILL cycle: 1 cycle.
- Latency from the edge accepting the word's final byte to `WE`: 1 cycle.
- Throughput: 4 bytes per 5 cycles with back-to-back `in_valid`.
- `done` is asserted in the cycle after the last WE cycle.
- For `byte_len`=0, `done` is asserted in the cycle after the `start` edge.
- A new `start` is accepted no earlier than the cycle after `done`.
- `DI` and `ADDR` hold their last values outside WRITE; only `WE` qualifies them.

## Test plan

- `base_addr`=0, `byte_len`=8, bytes 0x00..0x07 streamed with `in_valid` held high. Required response:
  - WE at addr 0 with DI=0x03020100.
  - WE at addr 1 with DI=0x07060504.
  - `done` one cycle after the second WE.
  - Exactly 2 WE pulses in total.
- `byte_len`=6, bytes 0x10..0x15. Required response: addr 0 gets 0x13121110, addr 1 gets 0x00001514, then `done`.
- `base_addr`=31, `byte_len`=8, ADDR_BIT=5. Required response: writes land at addr 31, then addr 0 (wrap), then `done`.
- `byte_len`=0 with a `start` pulse. Required response: `done` high in the next cycle, `busy` never high, WE never high.
- `in_valid` toggling 1,0,0,1,… across a 4-byte load, plus `start` re-pulsed while busy. Required response:
  - Single WE with correct packed word.
  - The re-pulsed `start` is ignored.
  - `in_ready` is never high during WRITE.
- `RSTn` low after 2 bytes accepted. Required response:
  - All outputs return to reset values asynchronously.
  - No WE is issued.
  - No `done` is pulsed.
  - A subsequent load of 4 bytes writes a clean word with no residue of the aborted bytes.
